// File: rtl/ddr2_init_checker_pkg.sv
// Shared encodings, state enum and error codes for the DDR2 power-up init checker.
package ddr2_init_checker_pkg;

  localparam int unsigned BA_BITS_DEF   = 3;
  localparam int unsigned ADDR_BITS_DEF = 14;
  localparam int unsigned CMD_W         = 4;
  localparam int unsigned ERR_W         = 3;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_LM   = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;

  localparam logic [ERR_W-1:0] ERR_NONE      = 3'd0;
  localparam logic [ERR_W-1:0] ERR_WRONG_CMD = 3'd1;
  localparam logic [ERR_W-1:0] ERR_SPACING   = 3'd2;
  localparam logic [ERR_W-1:0] ERR_OPERAND   = 3'd3;
  localparam logic [ERR_W-1:0] ERR_CKE_LOW   = 3'd4;

  typedef enum logic [3:0] {
    S_PRE1, S_EMR2, S_EMR3, S_EMR1A, S_MR_DLLRST, S_PRE2, S_REF1, S_REF2,
    S_MR, S_EMR1_OCD, S_EMR1_EXIT, S_DONE, S_ERR
  } state_e;

  typedef enum logic [2:0] {K_NONE, K_PRE, K_AREF, K_LM, K_OTHER} cmd_kind_e;

  function automatic cmd_kind_e decode_cmd(input logic [CMD_W-1:0] c);
    cmd_kind_e k;
    case (c)
      CMD_NOP:                  k = K_NONE;
      CMD_PRE:                  k = K_PRE;
      CMD_AREF:                 k = K_AREF;
      CMD_LM:                   k = K_LM;
      CMD_ACT, CMD_RD, CMD_WR:  k = K_OTHER;
      default:                  k = K_OTHER;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ddr2_cmd_gap_timer.sv
// Saturating cycles-since-last-command counter and the minimum-spacing check
// for the command currently on the bus.
module ddr2_cmd_gap_timer
  import ddr2_init_checker_pkg::*;
#(
  parameter int unsigned T_RP_CK  = 6,
  parameter int unsigned T_MRD_CK = 2,
  parameter int unsigned T_RFC_CK = 52,
  parameter int unsigned GAP_W    = 8
) (
  input  logic      ck,
  input  logic      rst_n,
  input  logic      cmd_valid,
  input  cmd_kind_e cmd_kind,
  output logic      spacing_ok_c
);

  logic [GAP_W-1:0] gap_cnt;
  cmd_kind_e        last_kind;

  // All-ones after reset so the first command always meets spacing.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      gap_cnt   <= '1;
      last_kind <= K_NONE;
    end else if (cmd_valid) begin
      gap_cnt   <= GAP_W'(1);
      last_kind <= cmd_kind;
    end else if (gap_cnt != '1) begin
      gap_cnt   <= gap_cnt + GAP_W'(1);
    end
  end

  always_comb begin
    spacing_ok_c = 1'b1;
    case (last_kind)
      K_PRE:   spacing_ok_c = (gap_cnt >= GAP_W'(T_RP_CK));
      K_LM:    spacing_ok_c = (gap_cnt >= GAP_W'(T_MRD_CK));
      K_AREF:  spacing_ok_c = (gap_cnt >= GAP_W'(T_RFC_CK));
      default: spacing_ok_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/ddr2_init_checker.sv
// DDR2 power-up init sequence monitor: walks the JEDEC order, checks operands
// and spacing, captures the mode registers, reports done or a sticky error.
module ddr2_init_checker
  import ddr2_init_checker_pkg::*;
#(
  parameter int unsigned BA_BITS   = BA_BITS_DEF,
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
  parameter int unsigned T_RP_CK   = 6,
  parameter int unsigned T_MRD_CK  = 2,
  parameter int unsigned T_RFC_CK  = 52,
  parameter int unsigned GAP_W     = 8
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic                 cke,
  input  logic [CMD_W-1:0]     cmd,
  input  logic [BA_BITS-1:0]   ba,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 init_done,
  output logic                 init_err,
  output logic [ERR_W-1:0]     err_code,
  output logic [ADDR_BITS-1:0] mr0,
  output logic [ADDR_BITS-1:0] emr1,
  output logic [ADDR_BITS-1:0] emr2,
  output logic [ADDR_BITS-1:0] emr3
);

  state_e             state_q, state_d, step;
  cmd_kind_e          kind, exp_kind;
  logic [BA_BITS-1:0] exp_ba;
  logic [ERR_W-1:0]   fault_code, code_d;
  logic               spacing_ok_c, bad_operand;

  assign kind = decode_cmd(cmd);

  ddr2_cmd_gap_timer #(
    .T_RP_CK  (T_RP_CK),
    .T_MRD_CK (T_MRD_CK),
    .T_RFC_CK (T_RFC_CK),
    .GAP_W    (GAP_W)
  ) u_gap (
    .ck           (ck),
    .rst_n        (rst_n),
    .cmd_valid    (kind != K_NONE),
    .cmd_kind     (kind),
    .spacing_ok_c (spacing_ok_c)
  );

  always_ff @(posedge ck) begin
    if (!rst_n) state_q <= S_PRE1;
    else        state_q <= state_d;
  end

  // Expected command per step, then the prioritised check.
  always_comb begin
    state_d    = state_q;
    step       = state_q;
    exp_kind   = K_NONE;
    exp_ba     = '0;
    fault_code = ERR_NONE;
    case (state_q)
      S_PRE1:      begin exp_kind = K_PRE;  step = S_EMR2; end
      S_EMR2:      begin exp_kind = K_LM;   exp_ba = BA_BITS'(2); step = S_EMR3;      end
      S_EMR3:      begin exp_kind = K_LM;   exp_ba = BA_BITS'(3); step = S_EMR1A;     end
      S_EMR1A:     begin exp_kind = K_LM;   exp_ba = BA_BITS'(1); step = S_MR_DLLRST; end
      S_MR_DLLRST: begin exp_kind = K_LM;   exp_ba = BA_BITS'(0); step = S_PRE2;      end
      S_PRE2:      begin exp_kind = K_PRE;  step = S_REF1; end
      S_REF1:      begin exp_kind = K_AREF; step = S_REF2; end
      S_REF2:      begin exp_kind = K_AREF; step = S_MR;   end
      S_MR:        begin exp_kind = K_LM;   exp_ba = BA_BITS'(0); step = S_EMR1_OCD;  end
      S_EMR1_OCD:  begin exp_kind = K_LM;   exp_ba = BA_BITS'(1); step = S_EMR1_EXIT; end
      S_EMR1_EXIT: begin exp_kind = K_LM;   exp_ba = BA_BITS'(1); step = S_DONE;      end
      default:     begin exp_kind = K_NONE; end
    endcase

    bad_operand = ((exp_kind == K_LM) && (ba != exp_ba))
               || ((exp_kind == K_PRE) && !addr[10])
               || ((state_q == S_EMR1_EXIT) && (addr[9:7] != 3'b000));

    if ((exp_kind != K_NONE) && (kind != K_NONE)) begin
      if (!cke)                  fault_code = ERR_CKE_LOW;
      else if (kind != exp_kind) fault_code = ERR_WRONG_CMD;
      else if (bad_operand)      fault_code = ERR_OPERAND;
      else if (!spacing_ok_c)    fault_code = ERR_SPACING;
      state_d = (fault_code != ERR_NONE) ? S_ERR : step;
    end

    code_d = (fault_code != ERR_NONE) ? fault_code : err_code;
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      init_err  <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      init_done <= (state_d == S_DONE);
      init_err  <= (state_d == S_ERR);
      err_code  <= code_d;
    end
  end

  // Mode registers follow every LM with cke high, even an offending one.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      mr0  <= '0;
      emr1 <= '0;
      emr2 <= '0;
      emr3 <= '0;
    end else if ((kind == K_LM) && cke) begin
      case (ba[1:0])
        2'd0:    mr0  <= addr;
        2'd1:    emr1 <= addr;
        2'd2:    emr2 <= addr;
        default: emr3 <= addr;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_init_checker.sv
// Scoreboard bench for ddr2_init_checker: each issued command queues the
// expected post-command outputs, a monitor queues what the DUT shows.
module tb_ddr2_init_checker;
  import ddr2_init_checker_pkg::*;

  localparam int unsigned T_RP  = 6;
  localparam int unsigned T_MRD = 2;
  localparam int unsigned T_RFC = 52;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke = 1'b1;
  logic [3:0]  cmd = CMD_NOP;
  logic [2:0]  ba = '0;
  logic [13:0] addr = '0;
  logic        init_done, init_err;
  logic [2:0]  err_code;
  logic [13:0] mr0, emr1, emr2, emr3;

  always #5 ck = ~ck;

  ddr2_init_checker #(
    .BA_BITS(3), .ADDR_BITS(14), .T_RP_CK(T_RP), .T_MRD_CK(T_MRD),
    .T_RFC_CK(T_RFC), .GAP_W(8)
  ) dut (
    .ck(ck), .rst_n(rst_n), .cke(cke), .cmd(cmd), .ba(ba), .addr(addr),
    .init_done(init_done), .init_err(init_err), .err_code(err_code),
    .mr0(mr0), .emr1(emr1), .emr2(emr2), .emr3(emr3)
  );

  typedef struct packed {
    logic        done;
    logic        err;
    logic [2:0]  code;
    logic [13:0] mr0, emr1, emr2, emr3;
  } snap_t;

  typedef struct {
    snap_t s;
    string tag;
  } exp_t;

  exp_t        exp_q[$];
  snap_t       obs_q[$];
  logic        track = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [13:0] e_mr [4] = '{default: '0};

  logic [3:0]  seq_cmd  [11] = '{CMD_PRE, CMD_LM, CMD_LM, CMD_LM, CMD_LM, CMD_PRE,
                                 CMD_AREF, CMD_AREF, CMD_LM, CMD_LM, CMD_LM};
  logic [2:0]  seq_ba   [11] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
  logic [13:0] seq_addr [11] = '{14'h0400, 14'h0000, 14'h0000, 14'h0000, 14'h0B62, 14'h0400,
                                 14'h0000, 14'h0000, 14'h0A62, 14'h0380, 14'h0000};
  int          seq_gap  [11] = '{0, T_RP, T_MRD, T_MRD, T_MRD, T_MRD, T_RP, T_RFC, T_RFC, T_MRD, T_MRD};

  function automatic snap_t cur_snap();
    snap_t s;
    s.done = init_done; s.err = init_err; s.code = err_code;
    s.mr0 = mr0; s.emr1 = emr1; s.emr2 = emr2; s.emr3 = emr3;
    return s;
  endfunction

  always @(posedge ck) begin
    if (track) begin
      #1;
      obs_q.push_back(cur_snap());
    end
  end

  // Called on a negedge; drives one command cycle and returns on the next negedge.
  task automatic issue(input logic [3:0] c, input logic [2:0] b, input logic [13:0] a,
                       input logic k, input logic ed, input logic ee,
                       input logic [2:0] ec, input string tag);
    exp_t e;
    cmd = c; ba = b; addr = a; cke = k; track = 1'b1;
    if (c == CMD_LM && k) e_mr[b[1:0]] = a;
    e.s.done = ed; e.s.err = ee; e.s.code = ec;
    e.s.mr0 = e_mr[0]; e.s.emr1 = e_mr[1]; e.s.emr2 = e_mr[2]; e.s.emr3 = e_mr[3];
    e.tag = tag;
    exp_q.push_back(e);
    @(negedge ck);
    cmd = CMD_NOP; cke = 1'b1; ba = '0; addr = '0; track = 1'b0;
  endtask

  task automatic nops(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic run_legal(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (i > 0) nops(seq_gap[i] - 1);
      issue(seq_cmd[i], seq_ba[i], seq_addr[i], 1'b1, (i == 10), 1'b0, ERR_NONE,
            $sformatf("%s_step%0d", tag, i));
    end
  endtask

  task automatic apply_reset(input logic with_cmd);
    rst_n = 1'b0; cke = 1'b1; addr = 14'h0400;
    cmd = with_cmd ? CMD_PRE : CMD_NOP;
    @(negedge ck);
    rst_n = 1'b1; cmd = CMD_NOP; addr = '0;
    for (int i = 0; i < 4; i++) e_mr[i] = '0;
  endtask

  task automatic test_reset();
    snap_t o;
    apply_reset(1'b1);
    o = cur_snap();
    checks++;
    if (o !== snap_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", o);
    end
  endtask

  task automatic test_legal_sequence();
    exp_t e; snap_t o;
    run_legal(11, "legal");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no output observed, required %h", e.tag, e.s);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.s) begin
          errors++;
          $display("FAIL %s: got done=%b err=%b code=%0d mr0=%h emr1=%h emr2=%h emr3=%h required done=%b err=%b code=%0d mr0=%h emr1=%h emr2=%h emr3=%h",
                   e.tag, o.done, o.err, o.code, o.mr0, o.emr1, o.emr2, o.emr3,
                   e.s.done, e.s.err, e.s.code, e.s.mr0, e.s.emr1, e.s.emr2, e.s.emr3);
        end
      end
    end
  endtask

  task automatic test_after_done();
    exp_t e; snap_t o;
    nops(2);
    issue(CMD_LM, 3'd0, 14'h0432, 1'b1, 1'b1, 1'b0, ERR_NONE, "done_lm_mr0");
    issue(CMD_PRE, 3'd0, 14'h0000, 1'b1, 1'b1, 1'b0, ERR_NONE, "done_unchecked_pre");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no output observed, required %h", e.tag, e.s);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.s) begin
          errors++; $display("FAIL %s: got %h required %h", e.tag, o, e.s);
        end
      end
    end
  endtask

  task automatic test_spacing();
    exp_t e; snap_t o;
    apply_reset(1'b0);
    issue(CMD_PRE, 3'd0, 14'h0400, 1'b1, 1'b0, 1'b0, ERR_NONE, "sp_pre1");
    nops(T_RP - 2);
    issue(CMD_LM, 3'd2, 14'h0004, 1'b1, 1'b0, 1'b1, ERR_SPACING, "sp_lm_gap5");
    nops(5);
    issue(CMD_LM, 3'd0, 14'h0123, 1'b1, 1'b0, 1'b1, ERR_SPACING, "sp_sticky");
    apply_reset(1'b0);
    run_legal(7, "sp_ref");
    nops(T_RFC - 2);
    issue(CMD_AREF, 3'd0, 14'h0000, 1'b1, 1'b0, 1'b1, ERR_SPACING, "sp_aref_gap51");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no output observed, required %h", e.tag, e.s);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.s) begin
          errors++; $display("FAIL %s: got %h required %h", e.tag, o, e.s);
        end
      end
    end
  endtask

  task automatic test_bad_operand();
    exp_t e; snap_t o;
    apply_reset(1'b0);
    issue(CMD_PRE, 3'd0, 14'h0000, 1'b1, 1'b0, 1'b1, ERR_OPERAND, "op_pre_a10_low");
    apply_reset(1'b0);
    issue(CMD_PRE, 3'd0, 14'h0400, 1'b1, 1'b0, 1'b0, ERR_NONE, "op_pre1");
    nops(T_RP - 1);
    issue(CMD_LM, 3'd3, 14'h0055, 1'b1, 1'b0, 1'b1, ERR_OPERAND, "op_wrong_ba");
    apply_reset(1'b0);
    run_legal(7, "op_wc");
    nops(T_RFC - 1);
    issue(CMD_LM, 3'd0, 14'h0111, 1'b1, 1'b0, 1'b1, ERR_WRONG_CMD, "op_lm_for_aref2");
    apply_reset(1'b0);
    run_legal(10, "op_exit");
    nops(T_MRD - 1);
    issue(CMD_LM, 3'd1, 14'h0080, 1'b1, 1'b0, 1'b1, ERR_OPERAND, "op_exit_a7");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no output observed, required %h", e.tag, e.s);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.s) begin
          errors++; $display("FAIL %s: got %h required %h", e.tag, o, e.s);
        end
      end
    end
  endtask

  task automatic test_cke_low();
    exp_t e; snap_t o;
    apply_reset(1'b0);
    issue(CMD_PRE, 3'd0, 14'h0400, 1'b0, 1'b0, 1'b1, ERR_CKE_LOW, "cke_pre_low");
    nops(1);
    issue(CMD_LM, 3'd2, 14'h0008, 1'b1, 1'b0, 1'b1, ERR_CKE_LOW, "cke_sticky");
    apply_reset(1'b0);
    cke = 1'b0;
    nops(3);
    cke = 1'b1;
    issue(CMD_PRE, 3'd0, 14'h0400, 1'b1, 1'b0, 1'b0, ERR_NONE, "cke_nops_then_pre");
    nops(T_RP - 1);
    issue(CMD_LM, 3'd2, 14'h0021, 1'b0, 1'b0, 1'b1, ERR_CKE_LOW, "cke_lm_low_nocap");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no output observed, required %h", e.tag, e.s);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.s) begin
          errors++; $display("FAIL %s: got %h required %h", e.tag, o, e.s);
        end
      end
    end
  endtask

  task automatic test_reset_midway();
    exp_t e; snap_t o;
    apply_reset(1'b0);
    run_legal(7, "mid");
    nops(3);
    apply_reset(1'b1);
    o = cur_snap();
    checks++;
    if (o !== snap_t'(0)) begin
      errors++; $display("FAIL mid_reset_clear: got %h required 0", o);
    end
    run_legal(11, "post_rst");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no output observed, required %h", e.tag, e.s);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.s) begin
          errors++; $display("FAIL %s: got %h required %h", e.tag, o, e.s);
        end
      end
    end
  endtask

  initial begin
    @(negedge ck);
    test_reset();
    test_legal_sequence();
    test_after_done();
    test_spacing();
    test_bad_operand();
    test_cke_low();
    test_reset_midway();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
